// File: rtl/ei_axi4_slave_mem_if.sv
// AXI4 bus bundle between a master and the ei_axi4_slave_mem responder.
// valid/ready: a transfer happens on a rising edge with valid=1 and ready=1; once valid rises, the sender holds valid and payload until ready.
interface ei_axi4_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave backed by a word-array memory; FIXED/INCR/WRAP bursts, one write and one read in flight, independent paths.
module ei_axi4_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic               aclk,
    input  logic               aresetn,
    ei_axi4_slave_mem_if.slave axi,
    output logic [1:0]         w_state_o,
    output logic [1:0]         r_state_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);
    localparam logic [2:0] MAX_SIZE    = 3'(OFF);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] base;
        bytes = ADDR_WIDTH'(1) << size;
        mask  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes - ADDR_WIDTH'(1);
        base  = addr & ~mask;
        case (burst)
            2'b01:   next_addr = addr + bytes;
            2'b10:   next_addr = base + ((addr + bytes - base) & mask);
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        burst_bad = (burst == 2'b11) ||
                    ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                    (size > MAX_SIZE);
    endfunction

    function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] addr);
        addr_oob = ({1'b0, addr} >= ADDR_LIMIT);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e              w_state_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_cnt_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q, w_resp_q;
    logic                  w_berr_q, w_err_q;
    logic                  w_last, w_beat_err, w_last_bad, w_fire, w_we;
    logic [IDXW-1:0]       w_idx;

    r_state_e              r_state_q;
    logic                  arready_q, rvalid_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_cnt_q;
    logic [2:0]            r_size_q;
    logic [1:0]            r_burst_q;
    logic                  r_berr_q;
    logic                  r_last, r_beat_err;
    logic [IDXW-1:0]       r_idx;

    assign w_addr_d   = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
    assign w_last     = (w_cnt_q == w_len_q);
    assign w_beat_err = w_berr_q || addr_oob(w_addr_q);
    assign w_last_bad = (axi.wlast != w_last);
    assign w_fire     = wready_q && axi.wvalid;
    assign w_we       = w_fire && !w_beat_err;
    assign w_idx      = w_addr_q[OFF +: IDXW];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_resp_q  <= RESP_OKAY;
            w_berr_q  <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awready_q && axi.awvalid) begin
                        w_id_q    <= axi.awid;
                        w_addr_q  <= axi.awaddr;
                        w_len_q   <= axi.awlen;
                        w_size_q  <= axi.awsize;
                        w_burst_q <= axi.awburst;
                        w_berr_q  <= burst_bad(axi.awlen, axi.awsize, axi.awburst);
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr_q <= w_addr_d;
                        w_cnt_q  <= w_cnt_q + 8'd1;
                        if (w_beat_err || w_last_bad) w_err_q <= 1'b1;
                        // Beat count, not wlast, ends the burst.
                        if (w_last) begin
                            w_resp_q  <= (w_err_q || w_beat_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axi.wstrb[b]) mem_q[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    assign r_addr_d   = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    assign r_last     = (r_cnt_q == r_len_q);
    assign r_beat_err = r_berr_q || addr_oob(r_addr_q);
    assign r_idx      = r_addr_q[OFF +: IDXW];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_berr_q  <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arready_q && axi.arvalid) begin
                        r_id_q    <= axi.arid;
                        r_addr_q  <= axi.araddr;
                        r_len_q   <= axi.arlen;
                        r_size_q  <= axi.arsize;
                        r_burst_q <= axi.arburst;
                        r_berr_q  <= burst_bad(axi.arlen, axi.arsize, axi.arburst);
                        r_cnt_q   <= '0;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        r_addr_q <= r_addr_d;
                        r_cnt_q  <= r_cnt_q + 8'd1;
                        if (r_last) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = w_id_q;
    assign axi.bresp   = w_resp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = r_id_q;
    assign axi.rlast   = rvalid_q && r_last;
    assign axi.rresp   = (rvalid_q && r_beat_err) ? RESP_SLVERR : RESP_OKAY;
    // Combinational read: a write landing at this edge is seen from the next cycle.
    assign axi.rdata   = (rvalid_q && !r_beat_err) ? mem_q[r_idx] : '0;

    assign w_state_o = w_state_q;
    assign r_state_o = r_state_q;
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Bench for ei_axi4_slave_mem: directed scenarios plus random bursts checked against a beat-address memory model.
module tb_ei_axi4_slave_mem;
    localparam int DW = 32, AW = 32, IW = 4, DEPTH = 1024;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b1;
    logic [1:0] w_state, r_state;
    int         errors = 0;
    int         checks = 0;

    ei_axi4_slave_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    ei_axi4_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn), .axi(bus), .w_state_o(w_state), .r_state_o(r_state)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference model: memory by word index, beat addresses from closed-form burst rules.
    logic [31:0] model_mem [int];
    logic [31:0] wr_data_q [$];
    logic [3:0]  wr_strb_q [$];
    logic [34:0] exp_q [$];   // {last, resp, data}
    logic [34:0] obs_q [$];

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        longint s, bytes, win, base;
        s     = longint'(start);
        bytes = longint'(1) << size;
        win   = (longint'(len) + 1) * bytes;
        base  = (s / win) * win;
        case (burst)
            2'b01:   beat_addr = 32'(s + i * bytes);
            2'b10:   beat_addr = 32'(base + (s - base + i * bytes) % win);
            default: beat_addr = start;
        endcase
    endfunction

    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        burst_bad = (burst == 2'b11) || (size > 3'd2) ||
                    (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15);
    endfunction

    task automatic model_write(input logic [31:0] start, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int last_at, output logic [1:0] resp);
        logic        err;
        logic [31:0] a, w;
        int          k;
        err = burst_bad(len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(start, i, size, len, burst);
            if (a >= 32'd4096) err = 1'b1;
            else if (!burst_bad(len, size, burst)) begin
                k = int'(a >> 2);
                if (!model_mem.exists(k)) model_mem[k] = 32'd0;
                w = model_mem[k];
                for (int b = 0; b < 4; b++) if (wr_strb_q[i][b]) w[b*8 +: 8] = wr_data_q[i][b*8 +: 8];
                model_mem[k] = w;
            end
            if ((i == last_at) != (i == int'(len))) err = 1'b1;
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic model_read(input logic [31:0] start, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst);
        logic [31:0] a, d;
        logic        bad;
        exp_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
            a   = beat_addr(start, i, size, len, burst);
            bad = burst_bad(len, size, burst) || (a >= 32'd4096);
            d   = bad ? 32'd0 : model_mem[int'(a >> 2)];
            exp_q.push_back({(i == int'(len)), (bad ? 2'b10 : 2'b00), d});
        end
    endtask

    // Drivers
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at, input int bready_delay,
                            output logic [3:0] got_id, output logic [1:0] got_resp, output logic wready_after_aw,
                            output logic bvalid_after_last, output logic awready_after_b, output int unstable);
        int t;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 100) begin @(posedge aclk); #1; t++; end
        if (t >= 100) begin checks++; errors++; $display("FAIL aw_timeout: awready=%0b, required 1", bus.awready); end
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        wready_after_aw = bus.wready;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1; bus.wdata = wr_data_q[i]; bus.wstrb = wr_strb_q[i]; bus.wlast = (i == last_at);
            t = 0;
            while (!bus.wready && t < 100) begin @(posedge aclk); #1; t++; end
            if (t >= 100) begin checks++; errors++; $display("FAIL w_timeout beat %0d: wready=0, required 1", i); end
            @(posedge aclk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bvalid_after_last = bus.bvalid;
        got_id = bus.bid; got_resp = bus.bresp; unstable = 0;
        for (int c = 0; c < bready_delay; c++) begin
            @(posedge aclk); #1;
            if (!bus.bvalid || bus.bid !== got_id || bus.bresp !== got_resp) unstable++;
        end
        bus.bready = 1'b1;
        t = 0;
        while (!bus.bvalid && t < 100) begin @(posedge aclk); #1; t++; end
        if (t >= 100) begin checks++; errors++; $display("FAIL b_timeout: bvalid=0, required 1"); end
        got_id = bus.bid; got_resp = bus.bresp;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        awready_after_b = bus.awready;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic toggle,
                           output logic rvalid_after_ar, output logic arready_after_last,
                           output int unstable, output int gaps, output logic [3:0] got_id);
        int          t, beats;
        logic        held, rr;
        logic [31:0] hd;
        logic        hl;
        obs_q.delete();
        unstable = 0; gaps = 0; got_id = '0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 100) begin @(posedge aclk); #1; t++; end
        if (t >= 100) begin checks++; errors++; $display("FAIL ar_timeout: arready=0, required 1"); end
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        rvalid_after_ar = bus.rvalid;
        beats = 0; t = 0; held = 1'b0; rr = 1'b1; hd = '0; hl = 1'b0;
        while (beats <= int'(len) && t < 1000) begin
            if (held) begin
                if (!bus.rvalid || bus.rdata !== hd || bus.rlast !== hl) unstable++;
                held = 1'b0;
            end
            bus.rready = toggle ? rr : 1'b1;
            rr = !rr;
            if (bus.rvalid) begin
                if (bus.rready) begin
                    obs_q.push_back({bus.rlast, bus.rresp, bus.rdata});
                    got_id = bus.rid;
                    beats++;
                end else begin
                    held = 1'b1; hd = bus.rdata; hl = bus.rlast;
                end
            end else if (beats > 0 && !toggle) gaps++;
            @(posedge aclk); #1;
            t++;
        end
        if (t >= 1000) begin checks++; errors++; $display("FAIL r_timeout: got %0d beats, required %0d", beats, int'(len) + 1); end
        bus.rready = 1'b0;
        arready_after_last = bus.arready;
    endtask

    logic [3:0]  g_id;
    logic [1:0]  g_resp, e_resp;
    logic        g_wr_aw, g_bv_last, g_aw_b, g_rv_ar, g_ar_last;
    int          g_unst, g_gaps;

    task automatic test_reset();
        #1 aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b, required 000000",
                {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast});
        end
        checks++;
        if ({bus.bid, bus.bresp, bus.rid, bus.rresp} !== 12'd0) begin
            errors++; $display("FAIL reset_payload: bid=%h bresp=%h rid=%h rresp=%h, required all 0",
                bus.bid, bus.bresp, bus.rid, bus.rresp);
        end
        checks++;
        if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", bus.rdata); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
            errors++; $display("FAIL reset_release: awready=%b arready=%b, required 1 1", bus.awready, bus.arready);
        end
    endtask

    task automatic test_single();
        wr_data_q = '{32'hDEADBEEF}; wr_strb_q = '{4'hF};
        do_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 0, 0, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h10, 8'd0, 3'd2, 2'b01, 0, e_resp);
        checks++;
        if ({g_wr_aw, g_bv_last, g_aw_b} !== 3'b111) begin
            errors++; $display("FAIL single_wtiming: wready@N+1,bvalid@M+1,awready@K+1=%b, required 111", {g_wr_aw, g_bv_last, g_aw_b});
        end
        checks++;
        if (g_resp !== e_resp || g_id !== 4'd3) begin
            errors++; $display("FAIL single_b: bresp=%0d bid=%0d, required %0d 3", g_resp, g_id, e_resp);
        end
        do_read(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h10, 8'd0, 3'd2, 2'b01);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL single_r: got %h (n=%0d), required %h", obs_q[0], obs_q.size(), exp_q[0]);
        end
        checks++;
        if ({g_rv_ar, g_ar_last} !== 2'b11 || g_id !== 4'd5) begin
            errors++; $display("FAIL single_rtiming: rvalid@N+1,arready@K+1=%b rid=%0d, required 11 5", {g_rv_ar, g_ar_last}, g_id);
        end
    endtask

    task automatic test_incr();
        wr_data_q = '{32'd1, 32'd2, 32'd3, 32'd4}; wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, 3, 0, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h100, 8'd3, 3'd2, 2'b01, 3, e_resp);
        checks++;
        if (g_bv_last !== 1'b1 || g_resp !== e_resp) begin
            errors++; $display("FAIL incr_b: bvalid@M+1=%b bresp=%0d, required 1 %0d", g_bv_last, g_resp, e_resp);
        end
        do_read(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h100, 8'd3, 3'd2, 2'b01);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL incr_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL incr_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (g_gaps != 0 || g_ar_last !== 1'b1) begin
            errors++; $display("FAIL incr_throughput: gaps=%0d arready@K+1=%b, required 0 1", g_gaps, g_ar_last);
        end
    endtask

    task automatic test_wrap();
        wr_data_q = '{32'hA, 32'hB, 32'hC, 32'hD}; wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'd4, 32'h0, 8'd3, 3'd2, 2'b01, 3, 0, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h0, 8'd3, 3'd2, 2'b01, 3, e_resp);
        do_read(4'd6, 32'h0C, 8'd3, 3'd2, 2'b10, 1'b0, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h0C, 8'd3, 3'd2, 2'b10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL wrap_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_errors();
        wr_data_q = '{32'h12345678}; wr_strb_q = '{4'hF};
        do_write(4'd7, 32'h1000, 8'd0, 3'd2, 2'b01, 0, 0, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h1000, 8'd0, 3'd2, 2'b01, 0, e_resp);
        checks++;
        if (g_resp !== e_resp) begin errors++; $display("FAIL err_oob_bresp: got %0d, required %0d", g_resp, e_resp); end
        do_read(4'd0, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h0, 8'd0, 3'd2, 2'b01);
        checks++;
        if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL err_oob_mem: word0 %h, required %h", obs_q[0], exp_q[0]); end

        do_read(4'd8, 32'h100, 8'd3, 3'd2, 2'b11, 1'b0, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h100, 8'd3, 3'd2, 2'b11);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL err_burst_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i][34:32] !== exp_q[i][34:32]) begin
                errors++; $display("FAIL err_burst_beat%0d: last/resp %b, required %b", i, obs_q[i][34:32], exp_q[i][34:32]);
            end
        end

        wr_data_q = '{32'd5, 32'd6, 32'd7, 32'd8}; wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'd9, 32'h100, 8'd3, 3'd2, 2'b01, 1, 0, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h100, 8'd3, 3'd2, 2'b01, 1, e_resp);
        checks++;
        if (g_resp !== e_resp || g_bv_last !== 1'b1) begin
            errors++; $display("FAIL err_wlast: bresp=%0d bvalid@M+1=%b, required %0d 1", g_resp, g_bv_last, e_resp);
        end
        do_read(4'd9, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h100, 8'd3, 3'd2, 2'b01);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL err_wlast_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        wr_data_q.delete(); wr_strb_q.delete();
        for (int i = 0; i < 8; i++) begin wr_data_q.push_back($urandom); wr_strb_q.push_back(4'hF); end
        do_write(4'hA, 32'h140, 8'd7, 3'd2, 2'b01, 7, 5, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h140, 8'd7, 3'd2, 2'b01, 7, e_resp);
        checks++;
        if (g_unst != 0 || g_resp !== e_resp || g_id !== 4'hA) begin
            errors++; $display("FAIL bp_b: unstable=%0d bresp=%0d bid=%h, required 0 %0d a", g_unst, g_resp, g_id, e_resp);
        end
        do_read(4'hB, 32'h140, 8'd7, 3'd2, 2'b01, 1'b1, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h140, 8'd7, 3'd2, 2'b01);
        checks++;
        if (g_unst != 0 || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_r_hold: unstable=%0d beats=%0d, required 0 %0d", g_unst, obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        wr_data_q = '{32'h11, 32'h22, 32'h33, 32'h44}; wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'd1, 32'h300, 8'd3, 3'd2, 2'b01, 3, 0, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h300, 8'd3, 3'd2, 2'b01, 3, e_resp);
        bus.awid = 4'd2; bus.awaddr = 32'h300; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wvalid = 1'b1; bus.wdata = 32'hA0 + 32'(i); bus.wstrb = 4'hF; bus.wlast = 1'b0;
            @(posedge aclk); #1;
            model_mem[192 + i] = 32'hA0 + 32'(i);
        end
        aresetn = 1'b0;
        bus.wvalid = 1'b0;
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0) begin
            errors++; $display("FAIL rstmid_async: ctrl=%b, required 00000",
                {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
        end
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0) begin
            errors++; $display("FAIL rstmid_held: ctrl=%b, required 00000",
                {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (bus.awready !== 1'b1) begin errors++; $display("FAIL rstmid_release: awready=%b, required 1", bus.awready); end
        do_read(4'd3, 32'h300, 8'd3, 3'd2, 2'b01, 1'b0, g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
        model_read(32'h300, 8'd3, 3'd2, 2'b01);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [31:0] start;
        int          bytes, span;
        wr_data_q.delete(); wr_strb_q.delete();
        for (int i = 0; i < 64; i++) begin wr_data_q.push_back($urandom); wr_strb_q.push_back(4'hF); end
        do_write(4'd0, 32'h400, 8'd63, 3'd2, 2'b01, 63, 0, g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
        model_write(32'h400, 8'd63, 3'd2, 2'b01, 63, e_resp);
        for (int n = 0; n < 24; n++) begin
            for (int pass = 0; pass < 2; pass++) begin
                burst = 2'($urandom_range(0, 2));
                size  = (pass == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 2));
                bytes = 1 << size;
                case (burst)
                    2'b10:   len = 8'((2 << $urandom_range(0, 3)) - 1);
                    2'b01:   len = 8'($urandom_range(0, 15));
                    default: len = 8'($urandom_range(0, 7));
                endcase
                span  = (burst == 2'b01) ? (int'(len) + 1) * bytes : bytes;
                start = 32'h400 + 32'($urandom_range(0, (256 - span) / bytes) * bytes);
                id    = 4'($urandom_range(0, 15));
                if (pass == 0) begin
                    wr_data_q.delete(); wr_strb_q.delete();
                    for (int i = 0; i <= int'(len); i++) begin
                        wr_data_q.push_back($urandom); wr_strb_q.push_back(4'($urandom_range(0, 15)));
                    end
                    do_write(id, start, len, size, burst, int'(len), int'($urandom_range(0, 2)),
                             g_id, g_resp, g_wr_aw, g_bv_last, g_aw_b, g_unst);
                    model_write(start, len, size, burst, int'(len), e_resp);
                    checks++;
                    if (g_resp !== e_resp || g_id !== id) begin
                        errors++; $display("FAIL rand%0d_b: bresp=%0d bid=%h, required %0d %h (addr=%h len=%0d size=%0d burst=%0d)",
                            n, g_resp, g_id, e_resp, id, start, len, size, burst);
                    end
                end else begin
                    do_read(id, start, len, size, burst, 1'($urandom_range(0, 1)), g_rv_ar, g_ar_last, g_unst, g_gaps, g_id);
                    model_read(start, len, size, burst);
                    checks++;
                    if (obs_q.size() != exp_q.size() || g_id !== id || g_unst != 0) begin
                        errors++; $display("FAIL rand%0d_r: beats=%0d rid=%h unstable=%0d, required %0d %h 0",
                            n, obs_q.size(), g_id, g_unst, exp_q.size(), id);
                    end
                    foreach (exp_q[i]) begin
                        checks++;
                        if (obs_q[i] !== exp_q[i]) begin
                            errors++; $display("FAIL rand%0d_beat%0d: got %h, required %h (addr=%h len=%0d size=%0d burst=%0d)",
                                n, i, obs_q[i], exp_q[i], start, len, size, burst);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ei_axi4_slave_mem.md
# ei_axi4_slave_mem

Synthesizable AXI4 slave responder backed by an internal word-array memory. It is the target end of the AXI4 interface driven by the VIP master agent, and the default DUT instantiated in the top-level bench. It supports FIXED, INCR and WRAP bursts with one outstanding write and one outstanding read transaction. The write and read paths run independently and concurrently.

## Interface
- DATA_WIDTH, 32: data bus width in bits. Legal values: 32 or 64.
- ADDR_WIDTH, 32: address bus width in bits.
- ID_WIDTH, 4: transaction ID width.
- MEM_DEPTH, 1024: memory size in DATA_WIDTH words. Must be a power of two.
- aclk  in  1  single clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel.
- awvalid  in  1;  awready  out  1.
- wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- wvalid  in  1;  wready  out  1.
- bid/bresp  out  ID_WIDTH/2  write response;  bvalid  out  1;  bready  in  1.
- arid/araddr/arlen/arsize/arburst  in  same widths as AW  read address channel.
- arvalid  in  1;  arready  out  1.
- rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data channel.
- rvalid  out  1;  rready  in  1.

## Operation
- Handshake: a transfer occurs on a rising edge with valid=1 and ready=1. Once the slave raises bvalid or rvalid, it holds that signal and all payload stable until the matching ready is seen.
- Write FSM:
  - W_IDLE: awready=1. AW handshake latches id, addr, len, size and burst, and moves to W_DATA.
  - W_DATA: wready=1. Each beat writes the bytes enabled by wstrb to the word at the current address, then advances the address. The beat with count == awlen moves to W_RESP.
  - W_RESP: bvalid=1, bid = latched id. B handshake returns to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. AR handshake latches the request and moves to R_DATA.
  - R_DATA: rvalid=1. rdata is the word at the current address. rlast=1 when count == arlen. Each R handshake advances the address. The handshake with rlast=1 returns to R_IDLE.
- Address update, with bytes = 2^size:
  - FIXED: address is unchanged.
  - INCR: addr += bytes.
  - WRAP: window = (len+1)*bytes, and base = addr aligned down to window. next = base + ((addr + bytes − base) mod window).
- Memory index = addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]. Reads always return the full word. Narrow lane selection is the master's responsibility.
- Error conditions produce SLVERR (2'b10); OKAY is 2'b00. Each condition below is evaluated on its own:
  - burst == 2'b11; WRAP with len not in {1,3,7,15}; or size > log2(DATA_WIDTH/8): the whole burst is errored.
  - Address ≥ MEM_DEPTH*DATA_WIDTH/8: the beat is errored. A write beat is dropped; a read beat returns rdata=0.
  - wlast disagrees with final-beat status: SLVERR on B. The beat count still governs burst length.
- Write response: bresp is SLVERR if any beat of the burst errored.
- Read response: rresp is per beat.
- Same-cycle write and read to the same word: the read beat presented in that cycle returns the old data. The new data is visible from the next cycle.

## Timing
- Reset (aresetn=0): awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0. bid, bresp, rid, rresp and rdata are all 0. Memory contents are not reset.
- On the first rising edge after aresetn deasserts, awready=1 and arready=1.
- AW handshake at edge N: awready=0 and wready=1 from N+1.
- Last W handshake at edge M: wready=0 and bvalid=1 from M+1.
- B handshake at edge K: awready=1 from K+1. Write burst turnaround is therefore 1 idle cycle.
- AR handshake at edge N: rvalid=1 with beat 0 from N+1.
- Read throughput is 1 beat per cycle while rready=1. A new beat appears in the cycle after each handshake.
- Last R handshake at edge K: arready=1 from K+1.
- Reset asserted mid-burst: both FSMs go immediately to idle and all outputs take their reset values. A partially written burst keeps the beats already committed.

## Test plan
- Single write then read: INCR len=0, size=2, awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF.
  - Required: bresp=OKAY at M+1, then rdata=0xDEADBEEF, rresp=OKAY, rlast=1.
- INCR len=3 at 0x100 with data 1,2,3,4 and bready, rready held at 1.
  - Required: B one cycle after the last W beat.
  - Required: read beats 1,2,3,4 on consecutive cycles, with rlast only on beat 4.
- WRAP len=3, size=2, araddr=0x0C after words 0x00..0x0C are loaded with A,B,C,D.
  - Required: read order D,A,B,C.
- Errors:
  - Write at 0x1000 (depth 1024 x 4 B): bresp=SLVERR and memory unchanged.
  - arburst=2'b11: every beat rresp=SLVERR.
  - wlast=1 on beat 1 of len=3: bresp=SLVERR and 4 beats are accepted.
- Backpressure: bready=0 for 5 cycles, then rready toggling 1/0 every cycle.
  - Required: bvalid, bid and bresp held stable until bready.
  - Required: rdata and rlast held stable while rready=0, with no beat skipped or repeated.
- Reset mid-burst: aresetn=0 after 2 of 4 W beats.
  - Required: all valids=0 and readys=0 while in reset. awready=1 one edge after release. Words 0 and 1 written; words 2 and 3 unchanged.
